shifter_pipe: RTL

// - Parametrised, pipelined barrel shifter for the execute stage; successor to the single-cycle 32-bit SLL.
// - Supports SLL, SRL, SRA (optional ROL/ROR); each log2 mux level shifts by 2^k, with registers inserted every REG_EVERY levels.
// - Valid/ready handshake on both sides with full-throughput stalling; a TAG travels with each operation (e.g. rd index).

---
 rtl/shifter_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/shifter_pipe.sv
// shifter_pipe -- pipelined barrel shifter for the execute stage.
//
// Each of the $clog2(WIDTH) mux levels shifts by 2^k when shamt[k] is set.
// Levels are grouped REG_EVERY at a time into pipeline stages, so the
// latency is LAT = ceil(SHAMT_W / REG_EVERY) cycles from accept to out_valid.
// A tag rides alongside each operation. Valid/ready is used on both sides,
// with a combinational back-pressure chain, so the pipe sustains one op per
// cycle and fills without bubbles when the consumer stalls.
//
// Ops: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR. Any other code is
// illegal; the result is then `a` unchanged and out_illegal is set.
// Optional feature macro: SHIFTER_ROTATE_EN. When it is defined, ROL and ROR
// are implemented. When it is undefined, the rotate muxes are absent and
// 011/100 are reported as illegal.
//
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake
//   a, shamt, op, in_tag     operation payload
//   out_valid/out_ready      output handshake
//   result, out_tag          shifted value and the tag of that operation
//   out_illegal              op code was illegal (or rotate not built)
module shifter_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [2:0]               op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAT     = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

  // Per-stage state
  logic [LAT-1:0]     valid_q, valid_d;
  logic [WIDTH-1:0]   data_q  [LAT];
  logic [WIDTH-1:0]   data_d  [LAT];
  logic [SHAMT_W-1:0] shamt_q [LAT];
  logic [SHAMT_W-1:0] shamt_d [LAT];
  logic [2:0]         op_q    [LAT];
  logic [2:0]         op_d    [LAT];
  logic [TAG_W-1:0]   tag_q   [LAT];
  logic [TAG_W-1:0]   tag_d   [LAT];
  logic [LAT-1:0]     ill_q, ill_d;

  // What each stage would capture: the input port for stage 0, otherwise the
  // previous stage's registers.
  logic [LAT-1:0]     src_valid, src_ill;
  logic [WIDTH-1:0]   src_data  [LAT];
  logic [SHAMT_W-1:0] src_shamt [LAT];
  logic [2:0]         src_op    [LAT];
  logic [TAG_W-1:0]   src_tag   [LAT];

  logic [LAT-1:0]     adv;   // stage hands its op downstream this cycle
  logic [LAT-1:0]     load;  // stage may capture from upstream this cycle
  logic               in_illegal;
  logic [WIDTH-1:0]   shifted;

  always_comb begin
`ifdef SHIFTER_ROTATE_EN
    in_illegal = (op > 3'd4);
`else
    in_illegal = (op > 3'd2);
`endif
  end

  // One mux level. amt is always a power of two below WIDTH, so the rotate
  // complement shift (WIDTH - amt) never reaches WIDTH.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x,
                                                   input logic [2:0] o,
                                                   input int amt);
    case (o)
      3'b000:  return x << amt;
      3'b001:  return x >> amt;
      3'b010:  return $unsigned($signed(x) >>> amt);  // sign bit of a replicates
`ifdef SHIFTER_ROTATE_EN
      3'b011:  return (x << amt) | (x >> (WIDTH - amt));
      3'b100:  return (x >> amt) | (x << (WIDTH - amt));
`endif
      default: return x;
    endcase
  endfunction

  always_comb begin
    // The back-pressure chain runs from the output back to the input. A
    // stage advances when the stage below it is empty or is itself
    // advancing.
    adv          = '0;
    adv[LAT-1]   = valid_q[LAT-1] & out_ready;
    for (int s = LAT - 2; s >= 0; s--) begin
      adv[s] = valid_q[s] & (~valid_q[s+1] | adv[s+1]);
    end
    load     = ~valid_q | adv;
    in_ready = load[0];

    src_valid[0] = in_valid;
    src_ill[0]   = in_illegal;
    src_data[0]  = a;
    src_shamt[0] = shamt;
    src_op[0]    = op;
    src_tag[0]   = in_tag;
    for (int s = 1; s < LAT; s++) begin
      src_valid[s] = valid_q[s-1];
      src_ill[s]   = ill_q[s-1];
      src_data[s]  = data_q[s-1];
      src_shamt[s] = shamt_q[s-1];
      src_op[s]    = op_q[s-1];
      src_tag[s]   = tag_q[s-1];
    end

    shifted = '0;
    for (int s = 0; s < LAT; s++) begin
      valid_d[s] = load[s] ? src_valid[s] : valid_q[s];
      data_d[s]  = data_q[s];
      shamt_d[s] = shamt_q[s];
      op_d[s]    = op_q[s];
      tag_d[s]   = tag_q[s];
      ill_d[s]   = ill_q[s];
      // The payload is captured only when a real op arrives. This keeps the
      // last result steady instead of loading don't-care data.
      if (load[s] && src_valid[s]) begin
        shifted = src_data[s];
        for (int k = 0; k < SHAMT_W; k++) begin
          if ((k / REG_EVERY) == s && src_shamt[s][k] && !src_ill[s]) begin
            shifted = shift_level(shifted, src_op[s], 1 << k);
          end
        end
        data_d[s]  = shifted;
        shamt_d[s] = src_shamt[s];
        op_d[s]    = src_op[s];
        tag_d[s]   = src_tag[s];
        ill_d[s]   = src_ill[s];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      ill_q   <= '0;
      for (int s = 0; s < LAT; s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= '0;
        tag_q[s]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ill_q   <= ill_d;
      for (int s = 0; s < LAT; s++) begin
        data_q[s]  <= data_d[s];
        shamt_q[s] <= shamt_d[s];
        op_q[s]    <= op_d[s];
        tag_q[s]   <= tag_d[s];
      end
    end
  end

  assign out_valid   = valid_q[LAT-1];
  assign result      = data_q[LAT-1];
  assign out_tag     = tag_q[LAT-1];
  assign out_illegal = ill_q[LAT-1];

endmodule
